// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for the shared 16-bit memory: a read-only fetch
// port and a read/write data port. Each access runs IDLE -> ACCESS -> RECOVER.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t            state, stateNext;
    logic              lastGrant, lastGrantNext;
    logic              grantPort, portNext;
    logic              grantWe, weNext;
    logic [DATA_W-1:0] wdataLat, wdataNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              readNext, writeNext;
    logic [ADDR_W-1:0] addrNext;
    logic              ack0Next, ack1Next, errNext;
    logic [DATA_W-1:0] rdata0Next, rdata1Next;
    logic              grantP1, done;

    // The memory only drives the bus while the write strobe is low, so this never contends.
    assign mem_data = mem_write ? wdataLat : {DATA_W{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            grantPort <= 1'b0;
            grantWe   <= 1'b0;
            wdataLat  <= '0;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            err       <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            state     <= stateNext;
            lastGrant <= lastGrantNext;
            grantPort <= portNext;
            grantWe   <= weNext;
            wdataLat  <= wdataNext;
            cnt       <= cntNext;
            mem_read  <= readNext;
            mem_write <= writeNext;
            mem_addr  <= addrNext;
            p0_ack    <= ack0Next;
            p1_ack    <= ack1Next;
            err       <= errNext;
            p0_rdata  <= rdata0Next;
            p1_rdata  <= rdata1Next;
        end
    end

    always_comb begin
        stateNext     = state;
        lastGrantNext = lastGrant;
        portNext      = grantPort;
        weNext        = grantWe;
        wdataNext     = wdataLat;
        cntNext       = cnt;
        readNext      = 1'b0;
        writeNext     = 1'b0;
        addrNext      = mem_addr;
        ack0Next      = 1'b0;
        ack1Next      = 1'b0;
        errNext       = 1'b0;
        rdata0Next    = p0_rdata;
        rdata1Next    = p1_rdata;
        grantP1       = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // On a tie the port that did not win last time is served.
                    grantP1       = p1_req && (!p0_req || !lastGrant);
                    portNext      = grantP1;
                    lastGrantNext = grantP1;
                    weNext        = grantP1 && p1_we;
                    wdataNext     = p1_wdata;
                    addrNext      = grantP1 ? p1_addr : p0_addr;
                    readNext      = !(grantP1 && p1_we);
                    writeNext     = grantP1 && p1_we;
                    cntNext       = '0;
                    stateNext     = ACCESS;
                end
            end
            ACCESS: begin
                cntNext   = cnt + CNT_W'(1);
                readNext  = mem_read;
                writeNext = mem_write;
                if (mem_ready) begin
                    done = 1'b1;
                    if (!grantWe) begin
                        if (grantPort) rdata1Next = mem_data;
                        else           rdata0Next = mem_data;
                    end
                end else if (cntNext == CNT_W'(TIMEOUT)) begin
                    done    = 1'b1;
                    errNext = 1'b1;
                end
                if (done) begin
                    readNext  = 1'b0;
                    writeNext = 1'b0;
                    ack0Next  = !grantPort;
                    ack1Next  = grantPort;
                    stateNext = RECOVER;
                end
            end
            RECOVER: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a bus-level memory, a transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;
    localparam logic [15:0] IDLE_BUS = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack, err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write, mem_ready;
    logic [15:0] mem_addr;
    wire  [15:0] mem_data;

    logic [15:0] memArr [256];
    logic [15:0] memOut;
    int          readyMode;
    int          total = 0;
    int          bad = 0;
    bit          chkOn = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .err(err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] initWord(input int i);
        if (i == 3) return 16'h1234;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Memory device: drives data while mem_read, a marker when idle, releases while written.
    assign memOut   = mem_read ? memArr[mem_addr[7:0]] : IDLE_BUS;
    assign mem_data = mem_write ? 16'bz : memOut;

    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = initWord(i);
        forever begin
            @(posedge clk);
            if (mem_write) memArr[mem_addr[7:0]] <= mem_data;
        end
    end

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       mem_ready = 1'b0;
                1:       mem_ready = ($urandom % 4) != 0;
                default: mem_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked by its age in access cycles.
    logic [15:0] refMem [256];
    bit          mActive, mRecov, mLastG, tPort, tWe;
    int          mAge;
    logic [15:0] tAddr, tData;
    logic        eRead, eWrite, eAck0, eAck1, eErr;
    logic [15:0] eAddr, eRd0, eRd1, eWdata;

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = initWord(i);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mActive = 0; mRecov = 0; mLastG = 1; mAge = 0;
                eRead = 0; eWrite = 0; eAck0 = 0; eAck1 = 0; eErr = 0;
                eAddr = 0; eRd0 = 0; eRd1 = 0; eWdata = 0;
            end else begin
                eAck0 = 0; eAck1 = 0; eErr = 0;
                if (mRecov) begin
                    mRecov = 0;
                end else if (mActive) begin
                    mAge++;
                    if (mem_ready || mAge >= TIMEOUT) begin
                        if (!mem_ready) eErr = 1;
                        else if (!tWe) begin
                            if (tPort) eRd1 = refMem[tAddr[7:0]];
                            else       eRd0 = refMem[tAddr[7:0]];
                        end
                        if (tPort) eAck1 = 1; else eAck0 = 1;
                        eRead = 0; eWrite = 0; mActive = 0; mRecov = 1;
                    end
                end else if (p0_req || p1_req) begin
                    tPort  = (p0_req && p1_req) ? !mLastG : p1_req;
                    mLastG = tPort;
                    tWe    = tPort && p1_we;
                    tAddr  = tPort ? p1_addr : p0_addr;
                    tData  = p1_wdata;
                    if (tWe) refMem[tAddr[7:0]] = tData;
                    eRead = !tWe; eWrite = tWe; eAddr = tAddr; eWdata = tData;
                    mActive = 1; mAge = 0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst && chkOn) begin
            chk("mem_read", mem_read, eRead);
            chk("mem_write", mem_write, eWrite);
            chk("mem_addr", mem_addr, eAddr);
            chk("p0_ack", p0_ack, eAck0);
            chk("p1_ack", p1_ack, eAck1);
            chk("err", err, eErr);
            chk("p0_rdata", p0_rdata, eRd0);
            chk("p1_rdata", p1_rdata, eRd1);
            if (eWrite)     chk("bus_wdata", mem_data, eWdata);
            else if (!eRead) chk("bus_released", mem_data, IDLE_BUS);
        end
    end

    task automatic access(input bit port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd, output bit e,
                          output int strobes);
        bit seen = 0;
        @(negedge clk);
        if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
        else begin p0_req = 1; p0_addr = addr; end
        strobes = 0; rd = '0; e = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mem_read || mem_write) strobes++;
            if (port ? p1_ack : p0_ack) begin
                seen = 1;
                rd = port ? p1_rdata : p0_rdata;
                e = err;
            end
        end
        if (!seen) chk(port ? "p1_ack_wait" : "p0_ack_wait", 32'(seen), 1);
        @(negedge clk);
        if (port) p1_req = 0; else p0_req = 0;
    endtask

    task automatic randPort(input bit port);
        logic [15:0] rd;
        bit e;
        int s;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            access(port, port ? 1'($urandom % 2) : 1'b0, 16'($urandom_range(0, 63)),
                   16'($urandom), rd, e, s);
        end
    endtask

    initial begin
        logic [15:0] rd;
        bit          e;
        int          s;
        int          ackPort [4];
        int          ackCyc [4];
        int          nAck;
        int          cyc;
        bit          firstSeen;
        int          expOrder [4] = '{0, 1, 0, 1};

        rst = 1; readyMode = 2;
        p0_req = 0; p0_addr = 0; p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_acks", {p0_ack, p1_ack, err}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("rst_bus", mem_data, IDLE_BUS);
        @(negedge clk);
        rst = 0;
        chkOn = 1;

        access(0, 0, 16'h0003, 0, rd, e, s);
        chk("t1_rdata", rd, 16'h1234);
        chk("t1_err", e, 0);
        chk("t1_strobe_cycles", 32'(s), 1);

        access(1, 1, 16'h001B, 16'hBEEF, rd, e, s);
        chk("t2_write_err", e, 0);
        chk("t2_write_cycles", 32'(s), 1);
        access(1, 0, 16'h001B, 0, rd, e, s);
        chk("t2_read_rdata", rd, 16'hBEEF);

        readyMode = 0;
        access(1, 0, 16'h0007, 0, rd, e, s);
        chk("t4_timeout_err", e, 1);
        chk("t4_timeout_cycles", 32'(s), TIMEOUT);
        chk("t4_rdata_kept", rd, 16'hBEEF);
        readyMode = 2;

        // Both ports held continuously: expect strict alternation starting with port 0.
        @(negedge clk);
        p0_req = 1; p0_addr = 16'h0010;
        p1_req = 1; p1_we = 0; p1_addr = 16'h0020;
        nAck = 0; cyc = 0;
        while (nAck < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (p0_ack && nAck < 4) begin ackPort[nAck] = 0; ackCyc[nAck] = cyc; nAck++; end
            if (p1_ack && nAck < 4) begin ackPort[nAck] = 1; ackCyc[nAck] = cyc; nAck++; end
        end
        @(negedge clk);
        p0_req = 0; p1_req = 0;
        chk("t3_ack_count", 32'(nAck), 4);
        for (int k = 0; k < nAck; k++) chk("t3_grant_order", 32'(ackPort[k]), 32'(expOrder[k]));
        for (int k = 1; k < nAck; k++) chk("t3_ack_spacing", 32'(ackCyc[k] - ackCyc[k-1]), 3);

        // Reset in the middle of a held-off write.
        readyMode = 0;
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_addr = 16'h0040; p1_wdata = 16'hCAFE;
        @(posedge clk);
        #1;
        chk("t5_write_started", mem_write, 1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("t5_write_dropped", mem_write, 0);
        chk("t5_bus_released", mem_data, IDLE_BUS);
        chk("t5_no_ack", {p0_ack, p1_ack, err}, 0);
        p1_req = 0;
        @(negedge clk);
        #1;
        chk("t5_still_quiet", {mem_read, mem_write, p1_ack}, 0);
        @(negedge clk);
        rst = 0;
        readyMode = 2;
        @(negedge clk);
        p0_req = 1; p0_addr = 16'h0005;
        p1_req = 1; p1_we = 0; p1_addr = 16'h0006;
        firstSeen = 0;
        for (int i = 0; i < 20 && !firstSeen; i++) begin
            @(posedge clk);
            #1;
            if (p0_ack || p1_ack) begin
                firstSeen = 1;
                chk("t5_first_after_rst", {p0_ack, p1_ack}, 2'b10);
            end
        end
        chk("t5_first_ack_seen", 32'(firstSeen), 1);
        @(negedge clk);
        p0_req = 0;
        firstSeen = 0;
        for (int i = 0; i < 20 && !firstSeen; i++) begin
            @(posedge clk);
            #1;
            if (p1_ack) firstSeen = 1;
        end
        chk("t5_p1_ack_seen", 32'(firstSeen), 1);
        @(negedge clk);
        p1_req = 0;

        readyMode = 1;
        fork
            randPort(0);
            randPort(1);
        join
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single shared 16-bit memory unit.
- Port 0 is the instruction-fetch port and is read-only. Port 1 is the data load/store port and supports read and write.
- Grants requesters round-robin and drives the memory's read/write strobes, address bus and bidirectional data bus.
- Waits for the memory ready flag, then returns data with a one-cycle acknowledge.

Parameters:
- ADDR_W, 16, address width, matching the memory address bus.
- DATA_W, 16, data width, matching the memory data bus.
- TIMEOUT, 15, maximum ACCESS cycles before an access is aborted with an error.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- p0_req  input  1  fetch request; held until p0_ack
- p0_addr  input  ADDR_W  fetch address; stable while p0_req
- p0_ack  output  1  one-cycle completion pulse
- p0_rdata  output  DATA_W  fetched word; valid while p0_ack
- p1_req  input  1  data request; held until p1_ack
- p1_we  input  1  1 = write, 0 = read; stable while p1_req
- p1_addr  input  ADDR_W  data address
- p1_wdata  input  DATA_W  write data
- p1_ack  output  1  one-cycle completion pulse
- p1_rdata  output  DATA_W  read word; valid while p1_ack
- err  output  1  one-cycle pulse, coincident with the ack of a timed-out access
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory address bus
- mem_data  inout  DATA_W  memory data bus
- mem_ready  input  1  memory ready flag

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-access):
  - State = IDLE.
  - mem_read, mem_write, p0_ack, p1_ack, err = 0.
  - mem_addr, p0_rdata, p1_rdata = 0.
  - mem_data released (high-Z).
  - last_grant = 1, so port 0 wins the first tie.
  - Timeout counter = 0.
  - Any in-flight access is dropped with no ack.
- All outputs are registered. mem_data is driven with the latched write data only while mem_write=1; otherwise it is high-Z. The memory drives the bus only when its write strobe is low, so there is never contention.
- State machine: IDLE -> ACCESS -> RECOVER -> IDLE.
- IDLE:
  - No request: stay in IDLE with all strobes low.
  - One request: grant that port.
  - Both requests: grant the port that is not last_grant.
  - On grant: latch port, address, we and wdata, and update last_grant. Set mem_addr. Set mem_read=1 for a read, or mem_write=1 for a write. Clear the counter and go to ACCESS.
- ACCESS:
  - Counter increments every cycle.
  - Completion is sampled at each rising edge in ACCESS. The first eligible edge is the one ending the first ACCESS cycle. This guarantees one write edge has occurred and the read data has settled.
  - If mem_ready=1 at that edge:
    - read: capture mem_data into the granted port's rdata.
    - write: nothing captured.
    - Pulse the granted port's ack, drop strobes, go to RECOVER.
  - Else if counter reaches TIMEOUT: pulse the ack and err together, leave rdata unchanged, drop strobes, go to RECOVER.
  - mem_addr stays stable throughout ACCESS.
- RECOVER:
  - Exactly one cycle with mem_read=mem_write=0 and the bus released.
  - ack (and err, if set) is high during this cycle. Go to IDLE.
  - The strobe-low gap re-arms the memory's read-edge detection for back-to-back accesses to the same address.
- Requester rule: a req still high in the IDLE cycle after ack is treated as a new request.
- Latency: grant is registered on the first IDLE edge with req high. Minimum 3 cycles from req to ack (IDLE, ACCESS, RECOVER); next grant is possible in the following cycle. Peak throughput is one access per 3 cycles.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1. Neither port waits for more than one foreign access.
- p0 has no write capability. Port 0 accesses always use mem_read.
- Input changes on a granted port during ACCESS are ignored because values were latched at grant.

Test Plan:
- Reset, then p0_req with p0_addr=0x0003 and memory word 3=0x1234 -> mem_read high for 1 cycle at address 3; p0_ack one cycle with p0_rdata=0x1234; err=0.
- p1 write 0xBEEF to 0x001B, then p1 read of 0x001B -> first access has mem_write=1 and bus=0xBEEF for one cycle, then ack. Second access returns p1_rdata=0xBEEF. Strobes are low for one cycle between the accesses.
- p0_req and p1_req asserted in the same cycle after reset, both held through 4 accesses -> grant order p0,p1,p0,p1; acks 3 cycles apart.
- Hold mem_ready=0 during a p1 read -> after 15 ACCESS cycles, p1_ack and err pulse together, strobes drop, and p1_rdata is unchanged.
- Assert rst in the middle of ACCESS during a p1 write -> mem_write drops immediately and mem_data goes high-Z. No ack is issued; after release the arbiter is in IDLE with last_grant=1.
